// File: rtl/sr_cmd_conditioner.sv
// Set/reset request front-end for sr_latch: synchronize, debounce and edge-detect two
// raw buttons, then emit mutually exclusive fixed-width pulses separated by a gap cycle.

module sr_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [DW-1:0] r_cnt;

  // Two-flop synchronizer, stability counter and delayed debounced level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // Any return to the current debounced level restarts the count.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  assign o_rise = r_deb & ~r_deb_d;

endmodule

module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_set_btn,
  input  logic in_rst_btn,
  output logic out_s,
  output logic out_r,
  output logic out_busy,
  output logic out_conflict
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  logic w_rise_s;
  logic w_rise_r;
  logic w_req_s;
  logic w_req_r;
  logic w_eff_s;
  logic w_eff_r;

  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic          r_pend_s;
  logic          r_pend_r;
  logic          r_s;
  logic          r_r;
  logic          r_busy;
  logic          r_conflict;

  state_t        w_nxt_state;
  logic [PW-1:0] w_nxt_pcnt;
  logic          w_nxt_pend_s;
  logic          w_nxt_pend_r;

  sr_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .i_clk   (in_clk),
    .i_rst_n (in_rst_n),
    .i_btn   (in_set_btn),
    .o_rise  (w_rise_s)
  );

  sr_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
    .i_clk   (in_clk),
    .i_rst_n (in_rst_n),
    .i_btn   (in_rst_btn),
    .o_rise  (w_rise_r)
  );

  // A simultaneous set edge is discarded so reset always wins a conflict.
  assign w_req_r = w_rise_r;
  assign w_req_s = w_rise_s & ~w_rise_r;
  assign w_eff_r = r_pend_r | w_req_r;
  assign w_eff_s = r_pend_s | w_req_s;

  // Next-state, pulse counter and one-deep pending request bookkeeping.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_pcnt   = r_pcnt;
    w_nxt_pend_s = r_pend_s;
    w_nxt_pend_r = r_pend_r;
    case (r_state)
      ST_IDLE: begin
        w_nxt_pcnt = '0;
        if (w_req_r) begin
          w_nxt_state = ST_PULSE_R;
        end else if (w_req_s) begin
          w_nxt_state = ST_PULSE_S;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_PULSE_S: begin
        w_nxt_pend_r = w_eff_r;
        if (r_pcnt == PULSE_LAST) begin
          w_nxt_state = ST_GAP;
          w_nxt_pcnt  = '0;
        end else begin
          w_nxt_pcnt  = r_pcnt + PW'(1);
        end
      end
      ST_PULSE_R: begin
        w_nxt_pend_s = w_eff_s;
        if (r_pcnt == PULSE_LAST) begin
          w_nxt_state = ST_GAP;
          w_nxt_pcnt  = '0;
        end else begin
          w_nxt_pcnt  = r_pcnt + PW'(1);
        end
      end
      ST_GAP: begin
        // Requests arriving during the gap are treated as pending.
        w_nxt_pcnt = '0;
        if (w_eff_r) begin
          w_nxt_state  = ST_PULSE_R;
          w_nxt_pend_r = 1'b0;
          w_nxt_pend_s = w_eff_s;
        end else if (w_eff_s) begin
          w_nxt_state  = ST_PULSE_S;
          w_nxt_pend_s = 1'b0;
          w_nxt_pend_r = 1'b0;
        end else begin
          w_nxt_state  = ST_IDLE;
          w_nxt_pend_s = 1'b0;
          w_nxt_pend_r = 1'b0;
        end
      end
      default: begin
        w_nxt_state  = ST_IDLE;
        w_nxt_pcnt   = '0;
        w_nxt_pend_s = 1'b0;
        w_nxt_pend_r = 1'b0;
      end
    endcase
  end

  // FSM registers with outputs registered from the next state.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state    <= ST_IDLE;
      r_pcnt     <= '0;
      r_pend_s   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_pcnt     <= w_nxt_pcnt;
      r_pend_s   <= w_nxt_pend_s;
      r_pend_r   <= w_nxt_pend_r;
      r_s        <= (w_nxt_state == ST_PULSE_S);
      r_r        <= (w_nxt_state == ST_PULSE_R);
      r_busy     <= (w_nxt_state != ST_IDLE) | w_nxt_pend_s | w_nxt_pend_r;
      r_conflict <= w_rise_s & w_rise_r;
    end
  end

  assign out_s        = r_s;
  assign out_r        = r_r;
  assign out_busy     = r_busy;
  assign out_conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed self-checking bench for sr_cmd_conditioner with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2.

module tb_sr_cmd_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic out_s;
  logic out_r;
  logic out_busy;
  logic out_conflict;

  int checks = 0;
  int failures = 0;

  sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) dut (
    .in_clk       (clk),
    .in_rst_n     (rst_n),
    .in_set_btn   (set_btn),
    .in_rst_btn   (rst_btn),
    .out_s        (out_s),
    .out_r        (out_r),
    .out_busy     (out_busy),
    .out_conflict (out_conflict)
  );

  always #5 clk = ~clk;

  // The latch must never see S and R together.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (out_s & out_r) begin
        failures++;
        $display("FAIL exclusive: out_s=%0b out_r=%0b at %0t, required not both 1", out_s, out_r, $time);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    set_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_s, out_r, out_busy, out_conflict} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000", {out_s, out_r, out_busy, out_conflict});
    end
  endtask

  // Release reset and raise set before edge 0; {s,r,busy,conflict} tracked per edge.
  task automatic test_single_set();
    logic [3:0] exp_v;
    rst_n = 1'b1;
    set_btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_v = {(k == 6 || k == 7), 1'b0, (k >= 6 && k <= 8), 1'b0};
      checks++;
      if ({out_s, out_r, out_busy, out_conflict} !== exp_v) begin
        failures++;
        $display("FAIL single_set edge %0d: got %b required %b", k, {out_s, out_r, out_busy, out_conflict}, exp_v);
      end
    end
  endtask

  task automatic test_falling_edge();
    logic seen;
    seen = 1'b0;
    set_btn = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_s | out_r | out_busy | out_conflict) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL falling_edge: activity=%0b required 0", seen);
    end
    checks++;
    if (dut.u_deb_set.r_deb !== 1'b0) begin
      failures++;
      $display("FAIL falling_deb_level: got %0b required 0", dut.u_deb_set.r_deb);
    end
  endtask

  task automatic test_glitch();
    logic seen_r;
    logic seen_deb;
    seen_r = 1'b0;
    seen_deb = 1'b0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int k = 0; k < 6; k++) begin
        rst_btn = (k < 3);
        @(negedge clk);
        if (out_r | out_busy) seen_r = 1'b1;
        if (dut.u_deb_rst.r_deb) seen_deb = 1'b1;
      end
    end
    rst_btn = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_r | out_busy) seen_r = 1'b1;
      if (dut.u_deb_rst.r_deb) seen_deb = 1'b1;
    end
    checks++;
    if (seen_r !== 1'b0) begin
      failures++;
      $display("FAIL glitch_out_r: activity=%0b required 0", seen_r);
    end
    checks++;
    if (seen_deb !== 1'b0) begin
      failures++;
      $display("FAIL glitch_deb_level: went high=%0b required 0", seen_deb);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_v;
    set_btn = 1'b1;
    rst_btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_v = {1'b0, (k == 6 || k == 7), (k >= 6 && k <= 8), (k == 6)};
      checks++;
      if ({out_s, out_r, out_busy, out_conflict} !== exp_v) begin
        failures++;
        $display("FAIL simultaneous edge %0d: got %b required %b", k, {out_s, out_r, out_busy, out_conflict}, exp_v);
      end
    end
    set_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  // Reset request debounces one cycle behind set, so it lands while out_s is high.
  task automatic test_queued();
    logic [3:0] exp_v;
    set_btn = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) rst_btn = 1'b1;
      exp_v = {(k == 6 || k == 7), (k == 9 || k == 10), (k >= 6 && k <= 11), 1'b0};
      checks++;
      if ({out_s, out_r, out_busy, out_conflict} !== exp_v) begin
        failures++;
        $display("FAIL queued edge %0d: got %b required %b", k, {out_s, out_r, out_busy, out_conflict}, exp_v);
      end
    end
    set_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    logic seen;
    seen = 1'b0;
    set_btn = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (out_s !== 1'b1) begin
      failures++;
      $display("FAIL mid_pulse_pre: out_s=%0b required 1", out_s);
    end
    #2;
    rst_n = 1'b0;
    set_btn = 1'b0;
    #1;
    checks++;
    if ({out_s, out_r, out_busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_pulse_async: got %b required 000", {out_s, out_r, out_busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_s | out_r | out_busy | out_conflict) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_pulse_after: activity=%0b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_falling_edge();
    test_glitch();
    test_simultaneous();
    test_queued();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
